bg_scroll_renderer: RTL
=======================

# bg_scroll_renderer

Parametrised background renderer: the next generation of the full-screen stretched-sprite background. It maps the VGA raster position to a palettised source image with a power-of-two upscale and per-frame vertical scrolling with wrap-around. It also holds a run-time writable palette and drives 12-bit RGB aligned to a delayed blank. It sits between the VGA controller (DrawX/DrawY/blank) and the colour mux that overlays the jets and bullets.

## Interface
Parameters:
- SRC_W, 320, source image width in pixels
- SRC_H, 240, source image height in pixels
- SCALE_SHIFT, 1, upscale factor as a shift (screen pixel >> SCALE_SHIFT = source pixel)
- ADDR_W, 17, ROM address width; must satisfy SRC_W*SRC_H <= 2^ADDR_W
- IDX_W, 4, palette index width; the palette has 2^IDX_W entries
- ROM_LAT, 1, external ROM read latency in vga_clk cycles (1..3)

Ports:
- vga_clk  in  1  pixel clock; all logic is on posedge
- reset_n  in  1  reset, synchronous, active-low
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- blank  in  1  1 = active video (VGA-controller convention)
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- scroll_en  in  1  1 = advance scroll offset at each frame_start
- scroll_speed  in  4  rows added to the offset per frame
- pal_we  in  1  palette write strobe
- pal_waddr  in  IDX_W  palette entry to write
- pal_wdata  in  12  {R[3:0],G[3:0],B[3:0]}
- rom_address  out  ADDR_W  to external image ROM
- rom_q  in  IDX_W  ROM data, valid ROM_LAT cycles after rom_address
- red, green, blue  out  4 each  pixel colour

## Operation
- Source coordinates: sx = DrawX >> SCALE_SHIFT and sy = DrawY >> SCALE_SHIFT.
  - ry = sy + offset. If ry >= SRC_H, subtract SRC_H (single conditional subtract; offset is always < SRC_H).
  - rom_address = ry*SRC_W + sx. The multiply is done at ADDR_W width.
- Out-of-range source pixels (sx >= SRC_W or sy >= SRC_H):
  - rom_address = 0.
  - Pixel is forced black via an oob flag carried down the pipeline.
- Scroll offset register, width clog2(SRC_H):
  - On frame_start with scroll_en=1: offset <= (offset + scroll_speed) mod SRC_H.
  - Otherwise the offset holds.
  - scroll_speed is sampled only on frame_start.
- Palette: 2^IDX_W x 12-bit register file.
  - Write is synchronous on pal_we.
  - Reset contents are a grey ramp: entry i = {i,i,i} truncated to 4 bits per channel.
  - A write and a read of the same entry in the same cycle: the read returns the old value.
- Output: active (delayed blank=1 and oob=0) gives the palette colour; otherwise 0,0,0.
- Reset values: red, green, blue = 0; rom_address = 0; offset = 0; all pipeline valid/blank/oob bits = 0; fade level = 0; fade FSM in F_IDLE.
- Reset asserted mid-frame:
  - Outputs are 0 from the cycle after the reset edge.
  - Offset restarts at 0.
  - The palette returns to the grey ramp.

## Timing
- Stage A: rom_address, blank_d and oob_d are registered from DrawX/DrawY/blank.
- ROM: ROM_LAT cycles; blank and oob are delayed by the same amount.
- Stage P: palette read, registered.
- Stage O: blank/oob gating and fade, registered to red/green/blue.
- Total latency from DrawX/DrawY/blank to RGB = ROM_LAT + 3 cycles, fixed. The VGA controller compensates.
- The offset update takes effect in the first stage-A cycle after frame_start. No tearing inside a frame, provided frame_start lies in vertical blanking.

## Configuration
- BG_FADE_EN defined: adds fade_req in (1-bit pulse), fade_dir in (1 = to black) and fade_busy out (reset 0).
  - FSM states: F_IDLE, F_STEP, F_HOLD.
  - fade_req in F_IDLE latches fade_dir and moves to F_STEP.
  - F_STEP: at each frame_start, level increments toward 15 (to black) or decrements toward 0.
  - Reaching the endpoint moves to F_HOLD, which returns to F_IDLE after one cycle.
  - fade_req is ignored while busy.
  - Each output channel = max(channel - level, 0).
- BG_FADE_EN undefined: no fade ports, no FSM, and the channels pass through unmodified.

## Structure
- Package bg_render_pkg:
  - rgb12_t, a packed struct with r, g, b fields of 4 bits each.
  - fade_state_t, the enum F_IDLE/F_STEP/F_HOLD.
  - Constants PAL_ENTRY_W=12 and FADE_MAX=15.
- Sub-module bg_palette_ram: the palette register file with reset ramp, one synchronous write port and one registered read port.

## Test plan
- Reset, then DrawX=0, DrawY=0, blank=1 with rom_q=5 → RGB=(5,5,5) exactly ROM_LAT+3 cycles later. During reset, RGB=0.
- Defaults, DrawX=639, DrawY=479 → rom_address = 239*320+319 = 76799. DrawX=2, DrawY=2 → 321.
- scroll_en=1, speed=10, 24 frame_start pulses → offset 0→240 mod 240 = 0. At offset 230, DrawY=40 (sy=20) → ry=10.
- pal_we to entry 5 with 12'hF00 in the same cycle as a read of 5 → old grey value; from the next pixel on → (15,0,0).
- SRC_W=256, DrawX=600 → oob, RGB=0 while blank=1. blank=0 → RGB=0 regardless of rom_q.
- BG_FADE_EN: fade_req with dir=1 on colour (15,8,2) → after 3 frames (12,5,0); fade_busy clears at level 15 with RGB=(0,0,0).

Source files
------------

// File: rtl/bg_render_pkg.sv
// Shared types and constants for the scrolling background renderer.
package bg_render_pkg;
  localparam int PAL_ENTRY_W = 12;
  localparam int FADE_MAX    = 15;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {F_IDLE, F_STEP, F_HOLD} fade_state_t;

  function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : 4'd0;
  endfunction
endpackage

// File: rtl/bg_palette_ram.sv
// Palette register file: grey-ramp reset, one synchronous write port, one registered read port.
module bg_palette_ram
  import bg_render_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  rgb12_t           wdata,
  input  logic [IDX_W-1:0] raddr,
  output rgb12_t           rdata
);
  localparam int N = 1 << IDX_W;

  rgb12_t [N-1:0] pal_q, pal_d;
  rgb12_t         rdata_q, rdata_d;

  // Read samples the pre-write contents, so a same-cycle write/read returns the old entry.
  always_comb begin
    pal_d = pal_q;
    if (we) pal_d[waddr] = wdata;
    rdata_d = pal_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) pal_q[i] <= '{r: 4'(i), g: 4'(i), b: 4'(i)};
      rdata_q <= '0;
    end else begin
      pal_q   <= pal_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/bg_scroll_renderer.sv
// Upscaled, vertically scrolling palettised background; latency ROM_LAT+3.
// Optional BG_FADE_EN adds a per-frame fade-to/from-black controller.
module bg_scroll_renderer
  import bg_render_pkg::*;
#(
  parameter int SRC_W       = 320,
  parameter int SRC_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int IDX_W       = 4,
  parameter int ROM_LAT     = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              scroll_en,
  input  logic [3:0]        scroll_speed,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_waddr,
  input  logic [11:0]       pal_wdata,
`ifdef BG_FADE_EN
  input  logic              fade_req,
  input  logic              fade_dir,
  output logic              fade_busy,
`endif
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);
  localparam int OFF_W  = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int STAGES = ROM_LAT + 1;

  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [OFF_W:0]    off_sum;
  logic [9:0]        sx, sy;
  logic [10:0]       ry;
  logic              oob_a;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STAGES:0]   blank_pipe_q, blank_pipe_d, oob_pipe_q, oob_pipe_d;
  rgb12_t            pal_rd, faded, rgb_q, rgb_d;

  // Offset stays below SRC_H and speed <= 15, so one conditional subtract wraps it.
  always_comb begin
    off_sum  = {1'b0, offset_q} + (OFF_W+1)'(scroll_speed);
    offset_d = offset_q;
    if (frame_start && scroll_en)
      offset_d = (off_sum >= (OFF_W+1)'(SRC_H)) ? OFF_W'(off_sum - (OFF_W+1)'(SRC_H))
                                                : off_sum[OFF_W-1:0];
  end

  always_comb begin
    sx    = DrawX >> SCALE_SHIFT;
    sy    = DrawY >> SCALE_SHIFT;
    oob_a = (32'(sx) >= SRC_W) || (32'(sy) >= SRC_H);
    ry    = {1'b0, sy} + 11'(offset_q);
    if (32'(ry) >= SRC_H) ry = ry - 11'(SRC_H);
    addr_d = oob_a ? '0 : (ADDR_W'(ry) * ADDR_W'(SRC_W) + ADDR_W'(sx));
    blank_pipe_d = {blank_pipe_q[STAGES-1:0], blank};
    oob_pipe_d   = {oob_pipe_q[STAGES-1:0], oob_a};
  end

  bg_palette_ram #(.IDX_W(IDX_W)) u_pal (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .we      (pal_we),
    .waddr   (pal_waddr),
    .wdata   (pal_wdata),
    .raddr   (rom_q),
    .rdata   (pal_rd)
  );

`ifdef BG_FADE_EN
  fade_state_t fade_state_q;
  logic [3:0]  fade_level_q;
  logic        fade_dir_q, fade_busy_q;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      fade_state_q <= F_IDLE;
      fade_level_q <= '0;
      fade_dir_q   <= 1'b0;
      fade_busy_q  <= 1'b0;
    end else begin
      case (fade_state_q)
        F_IDLE: if (fade_req) begin
          fade_dir_q   <= fade_dir;
          fade_state_q <= F_STEP;
          fade_busy_q  <= 1'b1;
        end
        F_STEP: if (frame_start) begin
          if (fade_dir_q ? (fade_level_q == 4'(FADE_MAX)) : (fade_level_q == 4'd0)) begin
            fade_state_q <= F_HOLD;
          end else begin
            fade_level_q <= fade_dir_q ? (fade_level_q + 4'd1) : (fade_level_q - 4'd1);
            if (fade_dir_q ? (fade_level_q == 4'(FADE_MAX-1)) : (fade_level_q == 4'd1))
              fade_state_q <= F_HOLD;
          end
        end
        F_HOLD: begin
          fade_state_q <= F_IDLE;
          fade_busy_q  <= 1'b0;
        end
        default: fade_state_q <= F_IDLE;
      endcase
    end
  end

  assign fade_busy = fade_busy_q;
`endif

  always_comb begin
    faded = pal_rd;
`ifdef BG_FADE_EN
    faded.r = sat_sub4(pal_rd.r, fade_level_q);
    faded.g = sat_sub4(pal_rd.g, fade_level_q);
    faded.b = sat_sub4(pal_rd.b, fade_level_q);
`endif
    rgb_d = (blank_pipe_q[STAGES] && !oob_pipe_q[STAGES]) ? faded : '0;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      offset_q     <= '0;
      addr_q       <= '0;
      blank_pipe_q <= '0;
      oob_pipe_q   <= '0;
      rgb_q        <= '0;
    end else begin
      offset_q     <= offset_d;
      addr_q       <= addr_d;
      blank_pipe_q <= blank_pipe_d;
      oob_pipe_q   <= oob_pipe_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rom_address = addr_q;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;
endmodule
